// File: rtl/toggle_memory.sv
// Per-ID single-bit toggle store: one synchronous read-modify-write toggle port
// and one asynchronous read port, shaped to map onto distributed RAM.
module toggle_memory #(
  parameter int MAX_IDS = 8,
  parameter int ID_W    = $clog2(MAX_IDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            toggle,
  input  logic [ID_W-1:0] toggle_id,
  input  logic [ID_W-1:0] read_id,
  output logic            read_data
);

  // The declaration initialiser gives a known all-zero state at configuration,
  // so the store is usable before the first rst.
  logic [MAX_IDS-1:0] mem = '0;

  // NOTE: this memory is cleared by reset on purpose; consumers rely on every ID
  // reading free afterwards. Non-blocking assignment keeps the read-modify-write
  // reading the pre-edge value, so a same-cycle read sees the old bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (toggle) begin
      mem[toggle_id] <= ~mem[toggle_id];
    end
  end

  // Zero-latency read with no bypass from the write port.
  assign read_data = mem[read_id];

endmodule

// File: tb/tb_toggle_memory.sv
// Scoreboard bench for toggle_memory: a driver pushes expected read values, a
// negedge monitor pops and compares them against read_data.
module tb_toggle_memory;

  localparam int MAX_IDS = 8;
  localparam int ID_W    = $clog2(MAX_IDS);

  typedef struct {
    string name;
    logic  exp;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            toggle = 1'b0;
  logic [ID_W-1:0] toggle_id = '0;
  logic [ID_W-1:0] read_id = '0;
  logic            read_data;

  exp_t            sb_q[$];
  bit              chk_en = 1'b0;
  int              n_cmp = 0;
  int              n_err = 0;
  logic [MAX_IDS-1:0] model = '0;

  toggle_memory #(.MAX_IDS(MAX_IDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .toggle    (toggle),
    .toggle_id (toggle_id),
    .read_id   (read_id),
    .read_data (read_data)
  );

  always #5 clk = ~clk;

  // Reference behaviour used for the gating sweep.
  always @(posedge clk) begin
    if (rst) model <= '0;
    else if (toggle) model[toggle_id] <= ~model[toggle_id];
  end

  // Monitor: read_data is sampled mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: read_data=%0b but scoreboard was empty", "no_expect", read_data);
      end else begin
        e = sb_q.pop_front();
        if (read_data !== e.exp) begin
          n_err++;
          $display("FAIL %s: read_id=%0d read_data=%0b expected=%0b",
                   e.name, read_id, read_data, e.exp);
        end
      end
    end
  end

  // One clock cycle of stimulus; optionally queues the value read_data must show.
  task automatic cyc(input logic r, input logic t, input int tid, input int rid,
                     input bit chk, input logic exp, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    toggle    = t;
    toggle_id = ID_W'(tid);
    read_id   = ID_W'(rid);
    chk_en    = chk;
    if (chk) begin
      e.name = nm;
      e.exp  = exp;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    logic [MAX_IDS-1:0] exp_v;

    // Power-up contents are zero before any reset.
    cyc(0, 0, 0, 5, 1, 1'b0, "powerup");

    // 1. Post-reset sweep.
    cyc(1, 0, 0, 0, 0, 1'b0, "");
    for (int i = 0; i < MAX_IDS; i++) cyc(0, 0, 0, i, 1, 1'b0, $sformatf("rst_sweep_%0d", i));

    // 2. Single toggle of ID 3.
    cyc(0, 1, 3, 3, 1, 1'b0, "t3_before");
    cyc(0, 0, 0, 3, 1, 1'b1, "t3_after");
    cyc(0, 0, 0, 2, 1, 1'b0, "t3_nbr2");
    cyc(0, 0, 0, 4, 1, 1'b0, "t3_nbr4");

    // 3. Same-cycle read and toggle: no bypass.
    cyc(0, 1, 5, 5, 1, 1'b0, "same_before");
    cyc(0, 1, 5, 5, 1, 1'b1, "same_after");
    cyc(0, 0, 0, 5, 1, 1'b0, "same_twice");

    // 4. Back-to-back toggles 0,1,7,1 from a clean state -> ID0=1, ID7=1.
    cyc(1, 0, 0, 0, 0, 1'b0, "");
    cyc(0, 1, 0, 0, 0, 1'b0, "");
    cyc(0, 1, 1, 0, 0, 1'b0, "");
    cyc(0, 1, 7, 0, 0, 1'b0, "");
    cyc(0, 1, 1, 0, 0, 1'b0, "");
    exp_v = 8'b1000_0001;
    for (int i = 0; i < MAX_IDS; i++) cyc(0, 0, 0, i, 1, exp_v[i], $sformatf("b2b_%0d", i));

    // 5. toggle low: toggle_id ignored; compared against the reference model.
    for (int i = 0; i < MAX_IDS; i++) cyc(0, 0, i, i, 1, model[i], $sformatf("gate_%0d", i));

    // 6. Reset priority over a same-cycle toggle of ID 4.
    cyc(0, 1, 2, 0, 0, 1'b0, "");
    cyc(0, 1, 6, 0, 0, 1'b0, "");
    cyc(1, 1, 4, 2, 1, 1'b1, "rst_cycle_old");
    for (int i = 0; i < MAX_IDS; i++) cyc(0, 0, 0, i, 1, 1'b0, $sformatf("rst_prio_%0d", i));

    cyc(0, 0, 0, 0, 0, 1'b0, "");

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/toggle_memory.md
Name: toggle_memory

Overview:
- Per-ID single-bit toggle store used by the instruction ID manager to track completion events.
- Each event source owns one instance and flips the bit of the ID it completes.
- The ID manager XORs the outputs of several instances to decide whether an ID is in flight or free.
- Sized for distributed RAM (LUTRAM): one synchronous write port (read-modify-write toggle) and one asynchronous read port.

Parameters:
- MAX_IDS, 8, number of tracked IDs; must be a power of two ≥ 2.
- ID_W, $clog2(MAX_IDS), width of the ID ports (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- toggle  input  1  when high, invert the stored bit at toggle_id on the next rising edge.
- toggle_id  input  ID_W  ID whose bit is inverted.
- read_id  input  ID_W  ID to read.
- read_data  output  1  current stored bit for read_id (combinational).

Behaviour:
- Storage: MAX_IDS single-bit entries mem[0..MAX_IDS-1].
- Power-up: all entries are 0 (initial value, so the block is usable before the first rst).
- Reset: when rst is high at a rising edge, all entries become 0.
  - rst has priority over toggle; a toggle in the same cycle is discarded.
  - read_data during the rst cycle still shows pre-reset contents; it shows 0 from the following cycle.
- Toggle: when rst is low and toggle is high at a rising edge, mem[toggle_id] <= ~mem[toggle_id]. All other entries are unchanged.
- toggle low: no state change; toggle_id is ignored.
- Read: read_data = mem[read_id], purely combinational, zero latency, no registered output.
- Same ID read and toggled in one cycle: no write-to-read bypass.
  - read_data shows the old value in that cycle.
  - It shows the inverted value after the edge.
- At most one toggle per cycle; there is one write port.
- IDs wrap naturally: indices 0..MAX_IDS-1 are all valid and no out-of-range index exists.
- Toggling the same ID twice, in consecutive or separated cycles, restores its original value.
- No handshake, no stall, no X-propagation on outputs after initialisation.
- rst is a plain synchronous clear with no other side effects.

Test Plan:
1. Post-reset sweep: assert rst 1 cycle, then read_id = 0..MAX_IDS-1 -> read_data = 0 for every ID.
2. Single toggle: toggle=1, toggle_id=3 for 1 cycle.
   - read_id=3 -> 1 after the edge.
   - read_id=2 and read_id=4 -> remain 0.
3. Same-cycle read/toggle: read_id=5, toggle_id=5, toggle=1 -> read_data=0 before the edge, 1 after. A second toggle -> back to 0.
4. Back-to-back toggles: toggle ID 0, 1, 7 on consecutive cycles, then ID 1 again -> final state ID0=1, ID1=0, ID7=1, all others 0.
5. Toggle gating: toggle=0 with toggle_id cycling through all IDs for 8 cycles -> contents unchanged, checked against a reference model.
6. Reset priority: set IDs 2 and 6 to 1, then rst=1 with toggle=1, toggle_id=4 in the same cycle -> afterwards all IDs read 0, including ID 4.
